// File: rtl/pacman_pkg.sv
// Shared types, widths and helpers for the Pacman game controller.
package pacman_pkg;

   localparam int unsigned STATE_W          = 3;
   localparam int unsigned LIVES_W          = 2;
   localparam int unsigned SCORE_W          = 16;
   localparam int unsigned PELLET_W         = 8;
   localparam int unsigned EXTRA_LIFE_SCORE = 10000;
   localparam int unsigned MAX_LIVES        = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_READY    = 3'd1,
      ST_PLAY     = 3'd2,
      ST_DYING    = 3'd3,
      ST_GAMEOVER = 3'd4,
      ST_WIN      = 3'd5
   } game_state_t;

   // Score addition that sticks at all-ones instead of wrapping.
   function automatic logic [SCORE_W-1:0] score_sat_add(input logic [SCORE_W-1:0] a,
                                                        input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/gc_frame_timer.sv
// Loadable frame-tick down-counter; done_c flags the tick that exhausts it
// (or an already-empty counter, so a zero load expires on the next clock).
module gc_frame_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         tick_i,
   output logic         done_c
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign done_c = (cnt_q == '0) || (tick_i && (cnt_q == W'(1)));

endmodule

// File: rtl/pacman_game_ctrl.sv
// Pacman game-flow controller: lives, score, pellets and phase sequencing.
// Optional macro PACMAN_EXTRA_LIFE_EN grants one bonus life per game at 10000 points.
module pacman_game_ctrl
   import pacman_pkg::*;
#(
   parameter int unsigned LIVES         = 3,
   parameter int unsigned PELLETS       = 244,
   parameter int unsigned READY_FRAMES  = 120,
   parameter int unsigned DEATH_FRAMES  = 60,
   parameter int unsigned PELLET_POINTS = 10
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                frame_tick,
   input  logic                over,
   input  logic                pellet_eaten,
   input  logic                start,
   output logic [STATE_W-1:0]  state,
   output logic                run,
   output logic                respawn,
   output logic [LIVES_W-1:0]  lives,
   output logic [SCORE_W-1:0]  score,
   output logic [PELLET_W-1:0] pellets_left,
   output logic                game_over,
   output logic                win
);

   localparam int unsigned MAX_FRAMES = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
   localparam int unsigned TMR_W      = (MAX_FRAMES < 2) ? 1 : $clog2(MAX_FRAMES + 1);

   game_state_t         state_q, state_d;
   logic [LIVES_W-1:0]  lives_q, lives_d, lives_tmp;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [PELLET_W-1:0] pellets_q, pellets_d;
   logic                respawn_q, respawn_d;
   logic                run_q, game_over_q, win_q;
   logic                tmr_load, tmr_done;
   logic [TMR_W-1:0]    tmr_val;
`ifdef PACMAN_EXTRA_LIFE_EN
   logic                bonus_q, bonus_d;
`endif

   // READY and DYING never overlap, so they share one timer.
   gc_frame_timer #(.W(TMR_W)) u_timer (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .tick_i     (frame_tick),
      .done_c     (tmr_done)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         lives_q     <= '0;
         score_q     <= '0;
         pellets_q   <= '0;
         respawn_q   <= 1'b0;
         run_q       <= 1'b0;
         game_over_q <= 1'b0;
         win_q       <= 1'b0;
`ifdef PACMAN_EXTRA_LIFE_EN
         bonus_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         score_q     <= score_d;
         pellets_q   <= pellets_d;
         respawn_q   <= respawn_d;
         run_q       <= (state_d == ST_PLAY);
         game_over_q <= (state_d == ST_GAMEOVER);
         win_q       <= (state_d == ST_WIN);
`ifdef PACMAN_EXTRA_LIFE_EN
         bonus_q     <= bonus_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      lives_d   = lives_q;
      lives_tmp = lives_q;
      score_d   = score_q;
      pellets_d = pellets_q;
      respawn_d = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = TMR_W'(READY_FRAMES);
`ifdef PACMAN_EXTRA_LIFE_EN
      bonus_d   = bonus_q;
`endif
      unique case (state_q)
         ST_IDLE, ST_GAMEOVER, ST_WIN: begin
            if (start) begin
               state_d   = ST_READY;
               lives_d   = LIVES_W'(LIVES);
               score_d   = '0;
               pellets_d = PELLET_W'(PELLETS);
               respawn_d = 1'b1;
               tmr_load  = 1'b1;
`ifdef PACMAN_EXTRA_LIFE_EN
               bonus_d   = 1'b0;
`endif
            end
         end
         ST_READY: begin
            if (tmr_done) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            // Pellet is accounted before the collision so a last-pellet tie wins.
            if (pellet_eaten && (pellets_q != '0)) begin
               score_d   = score_sat_add(score_q, SCORE_W'(PELLET_POINTS));
               pellets_d = pellets_q - PELLET_W'(1);
`ifdef PACMAN_EXTRA_LIFE_EN
               if (!bonus_q && (32'(score_d) >= EXTRA_LIFE_SCORE)) begin
                  bonus_d = 1'b1;
                  if (lives_tmp < LIVES_W'(MAX_LIVES)) lives_tmp = lives_tmp + LIVES_W'(1);
               end
`endif
            end
            if (pellet_eaten && (pellets_q == PELLET_W'(1))) begin
               state_d = ST_WIN;
            end else if (frame_tick && over) begin
               state_d   = ST_DYING;
               lives_tmp = (lives_tmp != '0) ? lives_tmp - LIVES_W'(1) : '0;
               tmr_load  = 1'b1;
               tmr_val   = TMR_W'(DEATH_FRAMES);
            end
            lives_d = lives_tmp;
         end
         ST_DYING: begin
            if (tmr_done) begin
               if (lives_q == '0) begin
                  state_d = ST_GAMEOVER;
               end else begin
                  state_d   = ST_READY;
                  respawn_d = 1'b1;
                  tmr_load  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign state        = state_q;
   assign run          = run_q;
   assign respawn      = respawn_q;
   assign lives        = lives_q;
   assign score        = score_q;
   assign pellets_left = pellets_q;
   assign game_over    = game_over_q;
   assign win          = win_q;

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Bench for pacman_game_ctrl: directed game scenarios then random play,
// every cycle compared against a rule-level game model.
module tb_pacman_game_ctrl;
   import pacman_pkg::*;

   localparam int unsigned LIVES         = 3;
   localparam int unsigned PELLETS       = 4;
   localparam int unsigned READY_FRAMES  = 2;
   localparam int unsigned DEATH_FRAMES  = 3;
   localparam int unsigned PELLET_POINTS = 10;

   logic                Clk = 1'b0;
   logic                Reset_n = 1'b0;
   logic                frame_tick = 1'b0;
   logic                over = 1'b0;
   logic                pellet_eaten = 1'b0;
   logic                start = 1'b0;
   logic [STATE_W-1:0]  state;
   logic                run, respawn, game_over, win;
   logic [LIVES_W-1:0]  lives;
   logic [SCORE_W-1:0]  score;
   logic [PELLET_W-1:0] pellets_left;

   int n_cmp = 0;
   int n_err = 0;

   // Reference game state at rule level
   game_state_t m_st = ST_IDLE;
   int m_lives = 0, m_score = 0, m_pel = 0, m_ticks = 0;
   bit m_rsp = 0, m_bonus = 0;

   pacman_game_ctrl #(
      .LIVES(LIVES), .PELLETS(PELLETS), .READY_FRAMES(READY_FRAMES),
      .DEATH_FRAMES(DEATH_FRAMES), .PELLET_POINTS(PELLET_POINTS)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .over(over),
      .pellet_eaten(pellet_eaten), .start(start), .state(state), .run(run),
      .respawn(respawn), .lives(lives), .score(score), .pellets_left(pellets_left),
      .game_over(game_over), .win(win)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = ST_IDLE; m_lives = 0; m_score = 0; m_pel = 0; m_ticks = 0;
      m_rsp = 0; m_bonus = 0;
   endtask

   task automatic model_step();
      m_rsp = 0;
      case (m_st)
         ST_IDLE, ST_GAMEOVER, ST_WIN: if (start) begin
            m_st = ST_READY; m_lives = LIVES; m_score = 0; m_pel = PELLETS;
            m_ticks = 0; m_rsp = 1; m_bonus = 0;
         end
         ST_READY: begin
            if (frame_tick) m_ticks++;
            if (READY_FRAMES == 0 || m_ticks >= READY_FRAMES) m_st = ST_PLAY;
         end
         ST_PLAY: begin
            bit last;
            last = 0;
            if (pellet_eaten) begin
               m_score = (m_score + PELLET_POINTS > 65535) ? 65535 : m_score + PELLET_POINTS;
               m_pel--;
`ifdef PACMAN_EXTRA_LIFE_EN
               if (!m_bonus && m_score >= 10000) begin
                  m_bonus = 1;
                  if (m_lives < 3) m_lives++;
               end
`endif
               last = (m_pel == 0);
            end
            if (last) m_st = ST_WIN;
            else if (frame_tick && over) begin
               m_lives--; m_st = ST_DYING; m_ticks = 0;
            end
         end
         ST_DYING: begin
            if (frame_tick) m_ticks++;
            if (DEATH_FRAMES == 0 || m_ticks >= DEATH_FRAMES) begin
               m_ticks = 0;
               if (m_lives == 0) m_st = ST_GAMEOVER;
               else begin m_st = ST_READY; m_rsp = 1; end
            end
         end
         default: m_st = ST_IDLE;
      endcase
   endtask

   task automatic check_all();
      chk("state", 32'(state), 32'(m_st));
      chk("run", 32'(run), 32'(m_st == ST_PLAY));
      chk("respawn", 32'(respawn), 32'(m_rsp));
      chk("lives", 32'(lives), 32'(m_lives));
      chk("score", 32'(score), 32'(m_score));
      chk("pellets_left", 32'(pellets_left), 32'(m_pel));
      chk("game_over", 32'(game_over), 32'(m_st == ST_GAMEOVER));
      chk("win", 32'(win), 32'(m_st == ST_WIN));
   endtask

   task automatic cyc(input logic t, input logic o, input logic p, input logic s);
      frame_tick = t; over = o; pellet_eaten = p; start = s;
      @(posedge Clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      #1;
      model_reset();
      chk("rst_state", 32'(state), 32'(ST_IDLE));
      chk("rst_run", 32'(run), 0);
      chk("rst_score", 32'(score), 0);
      check_all();
      @(posedge Clk);
      #1;
      check_all();
      Reset_n = 1'b1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2;
      do_reset();
      cyc(0, 0, 0, 0);

      // Start and ready sequencing
      cyc(0, 0, 0, 1);
      chk("start_respawn", 32'(respawn), 1);
      chk("start_state", 32'(state), 32'(ST_READY));
      cyc(0, 0, 0, 0);
      ticks(1);
      chk("ready_hold_run", 32'(run), 0);
      ticks(1);
      chk("ready_run", 32'(run), 1);
      chk("ready_lives", 32'(lives), 3);

      // Clear the maze
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 0);
         cyc(0, 0, 0, 0);
      end
      chk("win_score", 32'(score), 40);
      chk("win_pellets", 32'(pellets_left), 0);
      chk("win_flag", 32'(win), 1);
      chk("win_run", 32'(run), 0);

      // Collision sampling and death sequence
      cyc(0, 0, 0, 1);
      ticks(2);
      cyc(0, 1, 0, 0);
      chk("over_no_tick", 32'(state), 32'(ST_PLAY));
      cyc(1, 1, 0, 0);
      chk("die_state", 32'(state), 32'(ST_DYING));
      chk("die_lives", 32'(lives), 2);
      cyc(0, 0, 1, 1);
      ticks(3);
      chk("die_ready", 32'(state), 32'(ST_READY));
      chk("die_respawn", 32'(respawn), 1);

      // Lose every life
      ticks(2); cyc(1, 1, 0, 0); ticks(3);
      ticks(2); cyc(1, 1, 0, 0); ticks(3);
      chk("go_lives", 32'(lives), 0);
      chk("go_flag", 32'(game_over), 1);
      cyc(0, 0, 0, 1);
      chk("restart_state", 32'(state), 32'(ST_READY));
      chk("restart_lives", 32'(lives), 3);
      chk("restart_score", 32'(score), 0);

      // Last pellet and collision together
      ticks(2);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
      cyc(1, 1, 1, 0);
      chk("tie_state", 32'(state), 32'(ST_WIN));
      chk("tie_lives", 32'(lives), 3);

      // Reset in the middle of play
      cyc(0, 0, 0, 1);
      ticks(2);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
      chk("mid_score", 32'(score), 30);
      do_reset();

      // Random play
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         else cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pacman_game_ctrl.md
PACMAN_GAME_CTRL -- requirements
Module: pacman_game_ctrl

Interface
REQ-001 Parameter LIVES, 3: starting lives; legal range 1..3.
REQ-002 Parameter PELLETS, 244: pellets per maze; legal range 1..255.
REQ-003 Parameter READY_FRAMES, 120: frame ticks spent in READY.
REQ-004 Parameter DEATH_FRAMES, 60: frame ticks spent in DYING.
REQ-005 Parameter PELLET_POINTS, 10: score added per pellet.
REQ-006 Clk  in  1  system clock; all state changes on rising edge.
REQ-007 Reset_n  in  1  reset, asynchronous assert, active-low.
REQ-008 frame_tick  in  1  one-Clk pulse per video frame; positions are stable in this cycle.
REQ-009 over  in  1  combinational Pacman/ghost collision flag from the collision checker.
REQ-010 pellet_eaten  in  1  one-Clk pulse per pellet consumed.
REQ-011 start  in  1  level-sensitive start key.
REQ-012 state  out  3  current game_state_t.
REQ-013 run  out  1  high only in PLAY; enables Pacman and ghost motion.
REQ-014 respawn  out  1  one-Clk pulse; reload Pacman and ghost start positions.
REQ-015 lives  out  2  remaining lives.
REQ-016 score  out  16  accumulated score.
REQ-017 pellets_left  out  8  pellets remaining.
REQ-018 game_over, win  out  1 each  high while in GAMEOVER / WIN respectively.

Function
REQ-019 States SHALL be IDLE, READY, PLAY, DYING, GAMEOVER, WIN; all outputs SHALL be registered.
REQ-020 IDLE, GAMEOVER or WIN with start=1: next state READY; lives<=LIVES, score<=0, pellets_left<=PELLETS, respawn pulsed in the same cycle as the transition.
REQ-021 READY SHALL advance to PLAY on the READY_FRAMES-th frame_tick after entry; READY_FRAMES=0 advances on the first Clk after entry.
REQ-022 In PLAY, over SHALL be sampled only in cycles with frame_tick=1; over=1 then moves to DYING and decrements lives by 1 on that edge.
REQ-023 In PLAY, each pellet_eaten pulse SHALL add PELLET_POINTS to score, saturating at 16'hFFFF, and decrement pellets_left.
REQ-024 pellets_left reaching 0 SHALL move PLAY to WIN on the same edge as the decrement.
REQ-025 pellet_eaten and a sampled over in the same cycle: pellet is counted first; if it was the last pellet, next state is WIN and lives are unchanged, otherwise DYING.
REQ-026 pellet_eaten and over SHALL be ignored in every state except PLAY; start SHALL be ignored in READY, PLAY, DYING.
REQ-027 DYING SHALL last DEATH_FRAMES frame ticks, then go to GAMEOVER if lives=0, else to READY with respawn pulsed on the transition edge.
REQ-028 Score, lives and pellets_left SHALL hold their values through DYING, GAMEOVER and WIN.

Reset
REQ-029 Reset_n=0 SHALL immediately force state=IDLE, run=0, respawn=0, lives=0, score=0, pellets_left=0, game_over=0, win=0, frame counter=0, regardless of the current state.
REQ-030 After Reset_n deasserts, the first start=1 SHALL behave per REQ-020.

Configuration
REQ-031 Macro PACMAN_EXTRA_LIFE_EN: when defined, the first score update reaching or crossing 10000 since the last REQ-020 reload SHALL add one life, capped at 3, once per game; when undefined, lives only decrease after reload.

Structure
REQ-032 Package pacman_pkg SHALL hold game_state_t, EXTRA_LIFE_SCORE=10000 and the state encoding widths.
REQ-033 Sub-module gc_frame_timer SHALL provide a loadable frame-tick down-counter with a done output; READY and DYING share one instance.

Verification (READY_FRAMES=2, DEATH_FRAMES=3, PELLETS=4, LIVES=3)
REQ-034 Reset mid-PLAY with score=30 -> next edge state=IDLE, score=0, run=0.
REQ-035 start, then 2 frame ticks -> respawn pulse at start edge, run=1 after 2nd tick, lives=3.
REQ-036 4 pellet pulses in PLAY -> score=40, pellets_left=0, win=1, run=0.
REQ-037 over=1 without frame_tick -> stays PLAY; with frame_tick -> DYING, lives=2, after 3 ticks READY with respawn pulsed.
REQ-038 3 collisions -> lives=0, GAMEOVER after 3rd DYING; start -> READY, lives=3, score=0.
REQ-039 Last pellet and sampled over in the same cycle -> WIN, lives unchanged; with PACMAN_EXTRA_LIFE_EN and PELLET_POINTS=5000, lives go 3->3 (cap) at score 10000.
